// File: rtl/sy_ppl_div_iter.sv
// -----------------------------------------------------------------------------
// sy_ppl_div_iter
// Iterative radix-2 restoring divider for the MDU divide path. It resolves the
// RISC-V M-extension corner cases (divide-by-zero, signed overflow and the
// W-suffix forms) internally, and its latency depends only on the mode: N+3
// cycles from an accepted start, with N = DWTH for full width and DWTH/2 for
// word forms.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   start_i      accept a new divide when ready_o=1
//   sign_i       1: signed (DIV/REM), 0: unsigned (DIVU/REMU)
//   word_i       1: W form operating on the low DWTH/2 bits
//   dividend_i   rs1 raw register value
//   divisor_i    rs2 raw register value
//   kill_i       abort any in-flight operation (wins over start_i)
//   ready_o      idle or done, can accept start_i
//   busy_o       operation in flight (PREP/ITER/FIX)
//   valid_o      one-cycle result strobe
//   quotient_o   final quotient, held until the next accepted start
//   remainder_o  final remainder, held until the next accepted start
// -----------------------------------------------------------------------------
module sy_ppl_div_iter #(
    parameter int DWTH = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            sign_i,
    input  logic            word_i,
    input  logic [DWTH-1:0] dividend_i,
    input  logic [DWTH-1:0] divisor_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [DWTH-1:0] quotient_o,
    output logic [DWTH-1:0] remainder_o
);

    localparam int HW = DWTH / 2;
    localparam int CW = $clog2(DWTH) + 1;
    localparam logic [CW-1:0]   CNT_D  = CW'(DWTH);
    localparam logic [CW-1:0]   CNT_W  = CW'(HW);
    localparam logic [CW-1:0]   CNT_1  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DWTH-1:0] ZERO   = {DWTH{1'b0}};
    localparam logic [DWTH-1:0] ONES   = {DWTH{1'b1}};
    // Most-negative value at full width, and at word width already sign-extended.
    localparam logic [DWTH-1:0] MIN_D  = {1'b1, {(DWTH-1){1'b0}}};
    localparam logic [DWTH-1:0] MIN_W  = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Reduce an operand to the active width, sign- or zero-extending word forms.
    function automatic logic [DWTH-1:0] reduce_op(input logic [DWTH-1:0] v,
                                                  input logic w, input logic s);
        logic [DWTH-1:0] r;
        if (w) begin
            r = {{HW{s & v[HW-1]}}, v[HW-1:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Sign-extend the low half (word results, also for the unsigned W forms).
    function automatic logic [DWTH-1:0] sext_word(input logic [DWTH-1:0] v);
        return {{HW{v[HW-1]}}, v[HW-1:0]};
    endfunction

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic            ready_r, busy_r, valid_r;
    logic            sign_r, word_r, qneg_r, rneg_r, dz_r, ovf_r;
    // quo_r/dvs_r hold the raw operands between accept and PREP, then the
    // working dividend/quotient and |divisor| during ITER.
    logic [DWTH-1:0] quo_r, rem_r, dvs_r, orig_r;
    logic [DWTH-1:0] quotient_r, remainder_r;

    logic            accept_s;
    logic [DWTH-1:0] a_red_s, b_red_s, a_abs_s, b_abs_s, min_s;
    logic            sa_s, sb_s, dz_s, ovf_s;
    logic [DWTH:0]   tmp_s;
    logic [DWTH+1:0] diff_s;
    logic            borrow_s;
    logic [DWTH-1:0] q_raw_s, r_raw_s, q_fix_s, r_fix_s, q_res_s, r_res_s;

    // Next-state decode; kill_i overrides everything, including a start.
    always_comb begin
        state_nxt_s = state_r;
        if (kill_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: state_nxt_s = start_i ? ST_PREP : ST_IDLE;
                ST_PREP:          state_nxt_s = ST_ITER;
                ST_ITER:          state_nxt_s = (cnt_r == CNT_1) ? ST_FIX : ST_ITER;
                ST_FIX:           state_nxt_s = ST_DONE;
                default:          state_nxt_s = ST_IDLE;
            endcase
        end
    end

    assign accept_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start_i && !kill_i;

    // Operand reduction, absolute values and corner-case flags used in PREP.
    always_comb begin
        a_red_s = reduce_op(quo_r, word_r, sign_r);
        b_red_s = reduce_op(dvs_r, word_r, sign_r);
        sa_s    = sign_r & a_red_s[DWTH-1];
        sb_s    = sign_r & b_red_s[DWTH-1];
        a_abs_s = sa_s ? (ZERO - a_red_s) : a_red_s;
        b_abs_s = sb_s ? (ZERO - b_red_s) : b_red_s;
        min_s   = word_r ? MIN_W : MIN_D;
        dz_s    = (b_red_s == ZERO);
        ovf_s   = sign_r & (a_red_s == min_s) & (b_red_s == ONES);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        tmp_s    = {rem_r, quo_r[DWTH-1]};
        diff_s   = {1'b0, tmp_s} - {2'b00, dvs_r};
        borrow_s = diff_s[DWTH+1];
    end

    // Sign fix-up and corner-case overrides applied in FIX.
    always_comb begin
        q_raw_s = qneg_r ? (ZERO - quo_r) : quo_r;
        r_raw_s = rneg_r ? (ZERO - rem_r) : rem_r;
        if (dz_r) begin
            q_fix_s = ONES;
            r_fix_s = orig_r;
        end else if (ovf_r) begin
            q_fix_s = min_s;
            r_fix_s = ZERO;
        end else begin
            q_fix_s = q_raw_s;
            r_fix_s = r_raw_s;
        end
        q_res_s = word_r ? sext_word(q_fix_s) : q_fix_s;
        r_res_s = word_r ? sext_word(r_fix_s) : r_fix_s;
    end

    // State, iteration counter and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
            busy_r  <= (state_nxt_s == ST_PREP) || (state_nxt_s == ST_ITER) ||
                       (state_nxt_s == ST_FIX);
            valid_r <= (state_nxt_s == ST_DONE);
            if (state_r == ST_PREP) begin
                cnt_r <= word_r ? CNT_W : CNT_D;
            end else if (state_r == ST_ITER) begin
                cnt_r <= cnt_r - CNT_1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Datapath: latch on accept, prepare in PREP, iterate, publish result in FIX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sign_r      <= 1'b0;
            word_r      <= 1'b0;
            qneg_r      <= 1'b0;
            rneg_r      <= 1'b0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
            quo_r       <= ZERO;
            rem_r       <= ZERO;
            dvs_r       <= ZERO;
            orig_r      <= ZERO;
            quotient_r  <= ZERO;
            remainder_r <= ZERO;
        end else if (accept_s) begin
            quo_r  <= dividend_i;
            dvs_r  <= divisor_i;
            sign_r <= sign_i;
            word_r <= word_i;
        end else if (state_r == ST_PREP) begin
            rem_r  <= ZERO;
            // Word dividends are left-aligned so their top bit shifts out first.
            quo_r  <= word_r ? {a_abs_s[HW-1:0], {HW{1'b0}}} : a_abs_s;
            dvs_r  <= b_abs_s;
            orig_r <= a_red_s;
            qneg_r <= sa_s ^ sb_s;
            rneg_r <= sa_s;
            dz_r   <= dz_s;
            ovf_r  <= ovf_s;
        end else if (state_r == ST_ITER) begin
            rem_r <= borrow_s ? tmp_s[DWTH-1:0] : diff_s[DWTH-1:0];
            quo_r <= {quo_r[DWTH-2:0], ~borrow_s};
        end else if ((state_r == ST_FIX) && !kill_i) begin
            quotient_r  <= q_res_s;
            remainder_r <= r_res_s;
        end else begin
            quo_r <= quo_r;
        end
    end

    assign ready_o     = ready_r;
    assign busy_o      = busy_r;
    assign valid_o     = valid_r;
    assign quotient_o  = quotient_r;
    assign remainder_o = remainder_r;

endmodule
